// File: rtl/noc_rx_depacketizer_pkg.sv
// rtl/noc_rx_depacketizer_pkg.sv - NoC flit field layout, rx error codes and header/tail decode helpers
package Noc_parameters;

    localparam int Noc_Data_Width   = 32;
    localparam int Noc_ID_X_Width   = 2;
    localparam int Noc_ID_Y_Width   = 2;
    localparam int Noc_Point_H      = 28;
    localparam int Noc_Source_Point = 24;
    localparam int Noc_Dest_Point   = Noc_Source_Point - Noc_ID_X_Width - Noc_ID_Y_Width;
    localparam int Axi_Len_Point    = 8;
    localparam int Noc_Point_E      = 4;

    localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Head_H = 4'hA;
    localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Tail_H = 4'hC;
    localparam logic [Axi_Len_Point-Noc_Point_E-1:0]  Noc_Head_E = 4'h5;
    localparam logic [Axi_Len_Point-Noc_Point_E-1:0]  Noc_Tail_E = 4'h3;

    typedef enum logic [2:0] {
        NOC_RX_ERR_NONE         = 3'd0,
        NOC_RX_ERR_BAD_HEAD     = 3'd1,
        NOC_RX_ERR_DEST         = 3'd2,
        NOC_RX_ERR_ORPHAN       = 3'd3,
        NOC_RX_ERR_OVERFLOW     = 3'd4,
        NOC_RX_ERR_BAD_TAIL     = 3'd5,
        NOC_RX_ERR_EMPTY        = 3'd6,
        NOC_RX_ERR_HEAD_IN_BODY = 3'd7
    } noc_rx_err_e;

    function automatic logic noc_head_hit(input logic [Noc_Data_Width-1:0] d);
        return (d[Noc_Data_Width-1:Noc_Point_H] == Noc_Head_H) &&
               (d[Axi_Len_Point-1:Noc_Point_E] == Noc_Head_E);
    endfunction

    function automatic logic noc_tail_hit(input logic [Noc_Data_Width-1:0] d);
        return (d[Noc_Data_Width-1:Noc_Point_H] == Noc_Tail_H) &&
               (d[Axi_Len_Point-1:Noc_Point_E] == Noc_Tail_E);
    endfunction

endpackage

// File: rtl/noc_rx_depacketizer_payload_buf.sv
// rtl/noc_rx_depacketizer_payload_buf.sv - simple dual-port payload register array
module noc_rx_payload_buf
    import Noc_parameters::*;
#(
    parameter int MAX_PAYLOAD = 8,
    parameter int AW          = $clog2(MAX_PAYLOAD)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_ptr,
    input  logic [Noc_Data_Width-1:0] wr_data,
    input  logic [AW-1:0]             rd_ptr,
    output logic [Noc_Data_Width-1:0] rd_data
);

    logic [Noc_Data_Width-1:0] mem_q [MAX_PAYLOAD];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/noc_rx_depacketizer.sv
// rtl/noc_rx_depacketizer.sv - NoC local-port packet sink with framing checks and store-and-forward replay
module noc_rx_depacketizer
    import Noc_parameters::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID        = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID        = '0,
    parameter int                        MAX_PAYLOAD = 8
) (
    input  logic                             noc_clk,
    input  logic                             noc_rst_n,
    input  logic                             flit_valid,
    input  logic [Noc_Data_Width+1:0]        flit_in,
    output logic                             flit_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [Noc_Data_Width-1:0]        out_data,
    output logic                             out_last,
    output logic [Noc_ID_X_Width-1:0]        out_src_x,
    output logic [Noc_ID_Y_Width-1:0]        out_src_y,
    output logic [$clog2(MAX_PAYLOAD):0]     out_len,
    output logic                             err_valid,
    output logic [2:0]                       err_code,
    output logic [15:0]                      pkt_cnt
);

    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int CW = AW + 1;
    localparam int IW = Noc_ID_X_Width + Noc_ID_Y_Width;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [IW-1:0] src_q, src_d;
    logic          err_valid_q, err_valid_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic [Noc_Data_Width-1:0] dat, rd_data;
    logic [IW-1:0]             f_src, f_dst;
    logic                      is_head, is_tail, fire, wr_en, last_beat;
    logic                      take_head, hd_good, hd_err;
    logic [1:0]                hd_state;
    noc_rx_err_e               hd_code;

    assign dat       = flit_in[Noc_Data_Width-1:0];
    assign is_head   = flit_in[Noc_Data_Width+1];
    assign is_tail   = flit_in[Noc_Data_Width];
    assign f_src     = dat[Noc_Point_H-1:Noc_Source_Point];
    assign f_dst     = dat[Noc_Source_Point-1:Noc_Dest_Point];
    assign fire      = flit_valid && (state_q != S_DRAIN);
    assign last_beat = ({1'b0, rd_q} == count_q - CW'(1));

    // Head decode as seen from IDLE; a head+tail flit closes its own packet immediately.
    always_comb begin
        hd_good  = 1'b0;
        hd_err   = 1'b1;
        hd_state = is_tail ? S_IDLE : S_DROP;
        if (!noc_head_hit(dat)) begin
            hd_code = NOC_RX_ERR_BAD_HEAD;
        end else if (f_dst != {X_ID, Y_ID}) begin
            hd_code = NOC_RX_ERR_DEST;
        end else begin
            hd_good = 1'b1;
            if (is_tail) begin
                hd_code = NOC_RX_ERR_EMPTY;
            end else begin
                hd_code  = NOC_RX_ERR_NONE;
                hd_err   = 1'b0;
                hd_state = S_PAYLOAD;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_d        = rd_q;
        src_d       = src_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        pkt_cnt_d   = pkt_cnt_q;
        wr_en       = 1'b0;
        take_head   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (is_head) begin
                        take_head = 1'b1;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = NOC_RX_ERR_ORPHAN;
                    end
                end
            end
            S_PAYLOAD: begin
                if (fire) begin
                    if (is_head) begin
                        take_head = 1'b1;
                    end else if (is_tail) begin
                        state_d = S_IDLE;
                        if (!noc_tail_hit(dat) || f_src != src_q || f_dst != {X_ID, Y_ID}) begin
                            err_valid_d = 1'b1;
                            err_code_d  = NOC_RX_ERR_BAD_TAIL;
                        end else if (count_q == '0) begin
                            err_valid_d = 1'b1;
                            err_code_d  = NOC_RX_ERR_EMPTY;
                        end else begin
                            state_d = S_DRAIN;
                            rd_d    = '0;
                        end
                    end else if (count_q == CW'(MAX_PAYLOAD)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = NOC_RX_ERR_OVERFLOW;
                        state_d     = S_DROP;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
            end
            S_DROP: begin
                if (fire) begin
                    if (is_head) begin
                        take_head = 1'b1;
                    end else if (is_tail) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    if (last_beat) begin
                        state_d   = S_IDLE;
                        rd_d      = '0;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        rd_d = rd_q + AW'(1);
                    end
                end
            end
        endcase

        // A head arriving mid-packet reports the abandoned packet rather than the new head's own status.
        if (take_head) begin
            state_d = hd_state;
            if (state_q == S_PAYLOAD) begin
                err_valid_d = 1'b1;
                err_code_d  = NOC_RX_ERR_HEAD_IN_BODY;
            end else begin
                err_valid_d = hd_err;
                err_code_d  = hd_err ? hd_code : err_code_q;
            end
            if (hd_good) begin
                count_d = '0;
                src_d   = f_src;
            end
        end
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_q        <= '0;
            src_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            src_q       <= src_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    noc_rx_payload_buf #(
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .AW          (AW)
    ) u_buf (
        .clk     (noc_clk),
        .wr_en   (wr_en),
        .wr_ptr  (count_q[AW-1:0]),
        .wr_data (dat),
        .rd_ptr  (rd_q),
        .rd_data (rd_data)
    );

    assign flit_ready = (state_q != S_DRAIN);
    assign out_valid  = (state_q == S_DRAIN);
    assign out_data   = out_valid ? rd_data : '0;
    assign out_last   = out_valid && last_beat;
    assign out_src_x  = src_q[IW-1:Noc_ID_Y_Width];
    assign out_src_y  = src_q[Noc_ID_Y_Width-1:0];
    assign out_len    = count_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_noc_rx_depacketizer.sv
// tb/tb_noc_rx_depacketizer.sv - directed self-checking bench for noc_rx_depacketizer
module tb_noc_rx_depacketizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flit_valid;
    logic [33:0] flit_in;
    logic        flit_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  out_src_x;
    logic [1:0]  out_src_y;
    logic [3:0]  out_len;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    noc_rx_depacketizer #(
        .X_ID        (2'd1),
        .Y_ID        (2'd2),
        .MAX_PAYLOAD (8)
    ) dut (
        .noc_clk    (clk),
        .noc_rst_n  (rst_n),
        .flit_valid (flit_valid),
        .flit_in    (flit_in),
        .flit_ready (flit_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_src_x  (out_src_x),
        .out_src_y  (out_src_y),
        .out_len    (out_len),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .pkt_cnt    (pkt_cnt)
    );

    function automatic logic [33:0] hd(input logic [1:0] sx, sy, dx, dy);
        return {2'b10, 4'hA, sx, sy, dx, dy, 12'h000, 4'h5, 4'h0};
    endfunction

    function automatic logic [33:0] tl(input logic [1:0] sx, sy, dx, dy);
        return {2'b01, 4'hC, sx, sy, dx, dy, 12'h000, 4'h3, 4'h0};
    endfunction

    function automatic logic [33:0] bd(input logic [31:0] d);
        return {2'b00, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [33:0] f);
        @(negedge clk);
        chk("flit_ready_before_send", flit_ready, 1);
        flit_valid = 1'b1;
        flit_in    = f;
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        flit_in    = '0;
    endtask

    task automatic send_err(input string tag, input logic [33:0] f, input logic v, input logic [2:0] code);
        send(f);
        @(negedge clk);
        chk({tag, "_err_valid"}, err_valid, v);
        if (v) chk({tag, "_err_code"}, err_code, code);
    endtask

    initial begin
        rst_n      = 1'b0;
        flit_valid = 1'b0;
        flit_in    = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_flit_ready", flit_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_src", {out_src_x, out_src_y}, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);

        // single-flit packet
        send_err("t1_head", hd(0, 0, 1, 2), 0, 0);
        send_err("t1_body", bd(32'hA5), 0, 0);
        send_err("t1_tail", tl(0, 0, 1, 2), 0, 0);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_flit_ready", flit_ready, 0);
        chk("t1_out_data", out_data, 32'hA5);
        chk("t1_out_last", out_last, 1);
        chk("t1_src", {out_src_x, out_src_y}, 0);
        chk("t1_len", out_len, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_done_valid", out_valid, 0);
        chk("t1_done_ready", flit_ready, 1);
        chk("t1_pkt_cnt", pkt_cnt, 1);

        // destination mismatch
        send_err("t2_head", hd(0, 0, 3, 3), 1, 2);
        send_err("t2_body", bd(32'h1), 0, 0);
        send_err("t2_tail", tl(0, 0, 3, 3), 0, 0);
        chk("t2_out_valid", out_valid, 0);
        chk("t2_pkt_cnt", pkt_cnt, 1);

        // overflow on the ninth body flit
        send_err("t3_head", hd(2, 1, 1, 2), 0, 0);
        for (int i = 0; i < 8; i++) send_err("t3_body", bd(32'h100 + i), 0, 0);
        send_err("t3_body9", bd(32'h999), 1, 4);
        send_err("t3_tail", tl(2, 1, 1, 2), 0, 0);
        chk("t3_out_valid", out_valid, 0);
        send_err("t3_orphan", bd(32'h5), 1, 3);

        // backpressure with three beats
        send_err("t4_head", hd(3, 1, 1, 2), 0, 0);
        send_err("t4_b0", bd(32'h11), 0, 0);
        send_err("t4_b1", bd(32'h22), 0, 0);
        send_err("t4_b2", bd(32'h33), 0, 0);
        send_err("t4_tail", tl(3, 1, 1, 2), 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_ready", flit_ready, 0);
            chk("t4_hold_data", out_data, 32'h11);
            chk("t4_hold_last", out_last, 0);
            chk("t4_hold_len", out_len, 3);
            chk("t4_hold_src", {out_src_x, out_src_y}, 4'hD);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_beat1_data", out_data, 32'h22);
        chk("t4_beat1_last", out_last, 0);
        @(negedge clk);
        chk("t4_beat2_data", out_data, 32'h33);
        chk("t4_beat2_last", out_last, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_done_valid", out_valid, 0);
        chk("t4_pkt_cnt", pkt_cnt, 2);

        // head in place of tail restarts cleanly
        send_err("t5_head", hd(0, 1, 1, 2), 0, 0);
        send_err("t5_body", bd(32'h5A), 0, 0);
        send_err("t5_head2", hd(1, 0, 1, 2), 1, 7);
        send_err("t5_body2", bd(32'h77), 0, 0);
        send_err("t5_tail", tl(1, 0, 1, 2), 0, 0);
        chk("t5_out_data", out_data, 32'h77);
        chk("t5_len", out_len, 1);
        chk("t5_src", {out_src_x, out_src_y}, 4'h4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_pkt_cnt", pkt_cnt, 3);

        // bad marker, head+tail flit, bad tail
        send_err("t6_badhead", {2'b10, 4'hF, 8'h06, 12'h000, 4'h5, 4'h0}, 1, 1);
        send_err("t6_droptail", tl(0, 0, 1, 2), 0, 0);
        send_err("t6_headtail", hd(0, 0, 1, 2) | 34'h1_0000_0000, 1, 6);
        send_err("t6_orphan", tl(0, 0, 1, 2), 1, 3);
        send_err("t6_head", hd(0, 0, 1, 2), 0, 0);
        send_err("t6_body", bd(32'h9), 0, 0);
        send_err("t6_badtail", tl(1, 1, 1, 2), 1, 5);
        chk("t6_out_valid", out_valid, 0);

        // reset during drain
        send_err("t7_head", hd(0, 0, 1, 2), 0, 0);
        send_err("t7_body", bd(32'hBE), 0, 0);
        send_err("t7_tail", tl(0, 0, 1, 2), 0, 0);
        chk("t7_draining", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t7_out_valid", out_valid, 0);
        chk("t7_flit_ready", flit_ready, 1);
        chk("t7_err_valid", err_valid, 0);
        chk("t7_pkt_cnt", pkt_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
